// File: rtl/dcache_ctrl.sv
`default_nettype none
// dcache_ctrl: direct-mapped write-back data cache controller, rev 1.0
// Sequences frame-set updates for miss writeback/fill and the halt-time flush.
module dcache_ctrl #(
  parameter int DIDX_W = 3,
  parameter int DBLK_W = 1,
  parameter int DTAG_W = 32 - 2 - DBLK_W - DIDX_W
) (
  input  logic                            CLK,
  input  logic                            nRST,
  // datapath side
  input  logic                            dmemREN,
  input  logic                            dmemWEN,
  input  logic [31:0]                     dmemaddr,
  input  logic                            halt,
  output logic                            dhit,
  output logic                            flushed,
  // frame-set side
  output logic [31:0]                     cache_addr,
  input  logic                            fs_hit,
  input  logic                            fs_valid,
  input  logic                            fs_dirty,
  input  logic [DTAG_W-1:0]               fs_tag,
  input  logic [2**DBLK_W-1:0][31:0]      fs_data,
  output logic                            latch_en,
  output logic                            replace,
  output logic                            load_data,
  output logic                            set_valid,
  output logic                            clear_dirty,
  output logic                            write_tag,
  output logic [DBLK_W-1:0]               write_offset,
  output logic                            fs_wen,
  output logic [31:0]                     fs_dload,
  // memory side
  output logic                            dREN,
  output logic                            dWEN,
  output logic [31:0]                     daddr,
  output logic [31:0]                     dstore,
  input  logic                            dwait,
  input  logic [31:0]                     dload
);

  localparam int IDX_LO = 2 + DBLK_W;
  localparam int TAG_LO = IDX_LO + DIDX_W;
  localparam logic [DBLK_W-1:0] LAST_WORD = '1;
  localparam logic [DBLK_W-1:0] WCNT_ONE  = 1;
  localparam logic [DIDX_W:0]   FIDX_ONE  = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB        = 3'd1,
    FETCH     = 3'd2,
    FLUSH_CHK = 3'd3,
    FLUSH_WB  = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t              state;
  logic [DBLK_W-1:0]   wcnt;
  logic [DIDX_W:0]     fidx;
  logic                wb_end;

  logic                req;
  logic                miss;
  logic                hit;
  logic                flushing;
  logic                last_word;
  logic                fidx_end;
  logic [DIDX_W-1:0]   idx;

  assign req       = dmemREN | dmemWEN;
  assign hit       = req & fs_valid & fs_hit;
  assign miss      = req & ~(fs_valid & fs_hit);
  assign flushing  = (state == FLUSH_CHK) || (state == FLUSH_WB);
  assign last_word = (wcnt == LAST_WORD);
  assign fidx_end  = (fidx[DIDX_W-1:0] == '1);
  assign idx       = flushing ? fidx[DIDX_W-1:0] : dmemaddr[TAG_LO-1:IDX_LO];
  assign fs_dload  = dload;

  // During a flush the frame set is walked by fidx; otherwise it follows the request.
  assign cache_addr = flushing ? {{DTAG_W{1'b0}}, fidx[DIDX_W-1:0], {(DBLK_W+2){1'b0}}}
                               : dmemaddr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      wcnt   <= '0;
      fidx   <= '0;
      wb_end <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state <= (fs_valid & fs_dirty) ? WB : FETCH;
            wcnt  <= '0;
          end else if (halt) begin
            state <= FLUSH_CHK;
            fidx  <= '0;
          end
        end
        WB: begin
          if (!dwait) begin
            if (last_word) begin
              state <= FETCH;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + WCNT_ONE;
            end
          end
        end
        FETCH: begin
          if (!dwait) begin
            if (last_word) begin
              state <= IDLE;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + WCNT_ONE;
            end
          end
        end
        FLUSH_CHK: begin
          // fidx may already be past the last frame when the final frame was written back
          if (fidx[DIDX_W]) begin
            state <= DONE;
          end else if (fs_valid & fs_dirty) begin
            state  <= FLUSH_WB;
            wcnt   <= '0;
            wb_end <= 1'b0;
          end else begin
            fidx <= fidx + FIDX_ONE;
            if (fidx_end) state <= DONE;
          end
        end
        FLUSH_WB: begin
          if (wb_end) begin
            wb_end <= 1'b0;
            fidx   <= fidx + FIDX_ONE;
            state  <= FLUSH_CHK;
          end else if (!dwait) begin
            if (last_word) begin
              wcnt   <= '0;
              wb_end <= 1'b1;
            end else begin
              wcnt <= wcnt + WCNT_ONE;
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dhit         = 1'b0;
    fs_wen       = 1'b0;
    flushed      = 1'b0;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = '0;
    dstore       = '0;
    latch_en     = 1'b0;
    replace      = 1'b0;
    load_data    = 1'b0;
    set_valid    = 1'b0;
    clear_dirty  = 1'b0;
    write_tag    = 1'b0;
    write_offset = '0;
    case (state)
      IDLE: begin
        dhit   = hit;
        fs_wen = hit & dmemWEN;
      end
      WB, FLUSH_WB: begin
        if (state == FLUSH_WB && wb_end) begin
          latch_en    = 1'b1;
          replace     = 1'b1;
          clear_dirty = 1'b1;
        end else begin
          dWEN   = 1'b1;
          daddr  = {fs_tag, idx, wcnt, 2'b00};
          dstore = fs_data[wcnt];
        end
      end
      FETCH: begin
        dREN         = 1'b1;
        daddr        = {dmemaddr[31:TAG_LO], idx, wcnt, 2'b00};
        latch_en     = 1'b1;
        replace      = 1'b1;
        write_offset = wcnt;
        load_data    = ~dwait;
        if (!dwait && last_word) begin
          set_valid   = 1'b1;
          write_tag   = 1'b1;
          clear_dirty = 1'b1;
        end
      end
      DONE:    flushed = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
